debug_ocimem_arbiter: RTL and testbench

- Shares the 256x32 on-chip debug memory (OCI RAM) between two requesters, both in the system clock domain:
  - JTAG-side debug commands, arriving as take_action strobes plus the 38-bit jdo word.
  - CPU-side Avalon debug-memory slave accesses.
- Sequences RAM reads, writes and JTAG address auto-increment.
- Returns read data to MonDReg or the Avalon readdata port.
- Sits between the debug slave sysclk logic and the OCI RAM macro.

---
 rtl/debug_ocimem_arbiter_pkg.sv | 21 ++
 rtl/debug_ocimem_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_debug_ocimem_arbiter.sv | 399 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/debug_ocimem_arbiter_pkg.sv
// Shared types and constants for the OCI RAM arbiter.
// Holds the FSM state encoding and the jdo bit positions.
package debug_ocimem_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE,
        J_WR,
        J_RD,
        J_RDCAP,
        C_WR,
        C_RD,
        C_RDCAP
    } state_t;

    localparam int WR_FLAG   = 35;
    localparam int DATA_MSB  = 34;
    localparam int DATA_LSB  = 3;
    localparam int ADDR_LSB  = 17;
    localparam int RAM_DEPTH = 256;

endpackage

// File: rtl/debug_ocimem_arbiter.sv
// Arbitrates the OCI debug RAM between JTAG commands and the CPU Avalon slave.
// Define OCIMEM_ROUND_ROBIN_EN for round-robin contention; otherwise JTAG wins.
module debug_ocimem_arbiter
    import debug_ocimem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    output logic [DATA_W-1:0] MonDReg,
    output logic              jtag_busy,
    output logic              jtag_overrun,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [DATA_W-1:0] avs_writedata,
    input  logic [3:0]        avs_byteenable,
    output logic [DATA_W-1:0] avs_readdata,
    output logic              avs_waitrequest,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wren,
    output logic [DATA_W-1:0] ram_wdata,
    output logic [3:0]        ram_be,
    input  logic [DATA_W-1:0] ram_rdata
);

    state_t state;
    state_t next_state;

    logic [ADDR_W-1:0] jtag_addr;
    logic [DATA_W-1:0] pend_data;
    logic              pend_wr;
    logic              pend_inc;
    logic [DATA_W-1:0] cpu_rdata;

    logic cpu_req;
    logic strobe;
    logic pick_jtag;
    logic wren_raw;
    logic done_raw;
    logic cpu_done;

    logic unused_jdo;
    assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

    assign cpu_req = avs_read | avs_write;
    assign strobe  = take_action_ocimem_a | take_action_ocimem_b
                   | take_no_action_ocimem_a;

`ifdef OCIMEM_ROUND_ROBIN_EN
    logic last_jtag;
    assign pick_jtag = jtag_busy & (~cpu_req | ~last_jtag);
`else
    assign pick_jtag = jtag_busy;
`endif

    // Gating with reset keeps a half-finished access off the RAM and bus.
    assign ram_wren        = wren_raw & reset_n;
    assign cpu_done        = done_raw & reset_n;
    assign avs_waitrequest = cpu_req & ~cpu_done;
    assign avs_readdata    = (state == C_RDCAP && reset_n) ? ram_rdata
                                                           : cpu_rdata;

    always_comb begin
        next_state = state;
        ram_addr   = avs_address;
        ram_wdata  = avs_writedata;
        ram_be     = avs_byteenable;
        wren_raw   = 1'b0;
        done_raw   = 1'b0;
        unique case (state)
            IDLE: begin
                if (pick_jtag) begin
                    next_state = pend_wr ? J_WR : J_RD;
                end else if (cpu_req) begin
                    next_state = avs_write ? C_WR : C_RD;
                end
            end
            J_WR: begin
                ram_addr   = jtag_addr;
                ram_wdata  = pend_data;
                ram_be     = 4'hF;
                wren_raw   = 1'b1;
                next_state = IDLE;
            end
            J_RD: begin
                ram_addr   = jtag_addr;
                next_state = J_RDCAP;
            end
            J_RDCAP: begin
                ram_addr   = jtag_addr;
                next_state = IDLE;
            end
            C_WR: begin
                wren_raw   = 1'b1;
                done_raw   = 1'b1;
                next_state = IDLE;
            end
            C_RD: begin
                next_state = C_RDCAP;
            end
            C_RDCAP: begin
                done_raw   = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            jtag_addr    <= '0;
            pend_data    <= '0;
            pend_wr      <= 1'b0;
            pend_inc     <= 1'b0;
            cpu_rdata    <= '0;
            MonDReg      <= '0;
            jtag_busy    <= 1'b0;
            jtag_overrun <= 1'b0;
        end else begin
            state <= next_state;
            if (strobe && jtag_busy) begin
                jtag_overrun <= 1'b1;
            end
            // JTAG state only runs while busy, so loads never race increments.
            if (!jtag_busy) begin
                if (take_action_ocimem_a) begin
                    jtag_addr <= jdo[ADDR_LSB +: ADDR_W];
                end
                if (take_action_ocimem_b) begin
                    pend_wr   <= jdo[WR_FLAG];
                    pend_data <= jdo[DATA_MSB:DATA_LSB];
                    pend_inc  <= 1'b1;
                    jtag_busy <= 1'b1;
                end else if (take_no_action_ocimem_a) begin
                    pend_wr   <= 1'b0;
                    pend_inc  <= 1'b0;
                    jtag_busy <= 1'b1;
                end
            end
            case (state)
                J_WR: begin
                    MonDReg   <= pend_data;
                    jtag_addr <= jtag_addr + 1'b1;
                    jtag_busy <= 1'b0;
                end
                J_RDCAP: begin
                    MonDReg <= ram_rdata;
                    if (pend_inc) begin
                        jtag_addr <= jtag_addr + 1'b1;
                    end
                    jtag_busy <= 1'b0;
                end
                C_RDCAP: begin
                    cpu_rdata <= ram_rdata;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef OCIMEM_ROUND_ROBIN_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_jtag <= 1'b0;
        end else if (state == IDLE && next_state != IDLE) begin
            last_jtag <= pick_jtag;
        end
    end
`endif

endmodule

// File: tb/tb_debug_ocimem_arbiter.sv
// Bench for debug_ocimem_arbiter: vector table, corner sequences, random ops.
// Honours OCIMEM_ROUND_ROBIN_EN when predicting contention winners.
module tb_debug_ocimem_arbiter;

`ifdef OCIMEM_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    localparam int OP_JA  = 0;
    localparam int OP_JW  = 1;
    localparam int OP_JR  = 2;
    localparam int OP_JRR = 3;
    localparam int OP_CW  = 4;
    localparam int OP_CR  = 5;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [37:0] jdo = '0;
    logic        tao_a = 1'b0;
    logic        tao_b = 1'b0;
    logic        tnoa = 1'b0;
    logic [31:0] MonDReg;
    logic        jtag_busy;
    logic        jtag_overrun;
    logic [7:0]  avs_address = '0;
    logic        avs_read = 1'b0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic [3:0]  avs_byteenable = '0;
    logic [31:0] avs_readdata;
    logic        avs_waitrequest;
    logic [7:0]  ram_addr;
    logic        ram_wren;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_be;
    logic [31:0] ram_rdata;

    int total = 0;
    int bad = 0;

    logic [31:0] mem [256];
    logic        ram_init = 1'b1;
    int          wcount = 0;

    always #5 clk = ~clk;

    debug_ocimem_arbiter dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (tao_a),
        .take_action_ocimem_b    (tao_b),
        .take_no_action_ocimem_a (tnoa),
        .MonDReg                 (MonDReg),
        .jtag_busy               (jtag_busy),
        .jtag_overrun            (jtag_overrun),
        .avs_address             (avs_address),
        .avs_read                (avs_read),
        .avs_write               (avs_write),
        .avs_writedata           (avs_writedata),
        .avs_byteenable          (avs_byteenable),
        .avs_readdata            (avs_readdata),
        .avs_waitrequest         (avs_waitrequest),
        .ram_addr                (ram_addr),
        .ram_wren                (ram_wren),
        .ram_wdata               (ram_wdata),
        .ram_be                  (ram_be),
        .ram_rdata               (ram_rdata)
    );

    function automatic logic [31:0] pat(int i);
        logic [7:0] b;
        b = i[7:0];
        if (b >= 8'h20 && b < 8'h30) return 32'h0;
        return {8'hA5, b, ~b, b};
    endfunction

    // Registered-read RAM with byte-lane writes.
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= pat(i);
        end else if (ram_wren) begin
            for (int b = 0; b < 4; b++)
                if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            wcount <= wcount + 1;
        end
        ram_rdata <= mem[ram_addr];
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [37:0] mk_addr(logic [7:0] a);
        logic [37:0] j;
        j = '0;
        j[24:17] = a;
        return j;
    endfunction

    function automatic logic [37:0] mk_data(logic wr, logic [31:0] d);
        logic [37:0] j;
        j = '0;
        j[35] = wr;
        j[34:3] = d;
        return j;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        ram_init = 1'b1;
        @(negedge clk);
        ram_init = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic jtag_op(input int kind, input logic [37:0] word);
        int n;
        @(negedge clk);
        jdo = word;
        tao_a = (kind == 0);
        tao_b = (kind == 1);
        tnoa = (kind == 2);
        @(negedge clk);
        tao_a = 1'b0;
        tao_b = 1'b0;
        tnoa = 1'b0;
        n = 0;
        if (kind != 0) begin
            while (jtag_busy && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (jtag_busy) check("jtag_timeout", 32'(jtag_busy), 32'h0);
        end
    endtask

    task automatic cpu_op(input bit rd, input bit wr, input logic [7:0] a,
                          input logic [31:0] d, input logic [3:0] be,
                          output logic [31:0] rdata, output int waits);
        @(negedge clk);
        avs_address = a;
        avs_read = rd;
        avs_write = wr;
        avs_writedata = d;
        avs_byteenable = be;
        waits = 0;
        #1;
        while (avs_waitrequest && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        rdata = avs_readdata;
        if (avs_waitrequest) waits = -1;
        @(posedge clk);
        #1;
        avs_read = 1'b0;
        avs_write = 1'b0;
    endtask

    // JTAG read pending and CPU read arriving at the FSM in the same cycle.
    task automatic contend(input logic [7:0] caddr, output int tj,
                           output int tc, output logic [31:0] rd);
        @(negedge clk);
        jdo = mk_data(1'b0, 32'h0);
        tao_b = 1'b1;
        @(negedge clk);
        tao_b = 1'b0;
        avs_address = caddr;
        avs_read = 1'b1;
        tj = -1;
        tc = -1;
        rd = '0;
        for (int c = 1; c <= 30 && (tj < 0 || tc < 0); c++) begin
            @(negedge clk);
            if (tj < 0 && !jtag_busy) tj = c;
            if (tc < 0 && !avs_waitrequest) begin
                tc = c;
                rd = avs_readdata;
                @(posedge clk);
                #1;
                avs_read = 1'b0;
            end
        end
        avs_read = 1'b0;
    endtask

    task automatic mid_reset(input bit wr, input string tag);
        int wc0;
        jtag_op(0, mk_addr(8'h60));
        wc0 = wcount;
        @(negedge clk);
        jdo = mk_data(wr, 32'h0BADF00D);
        tao_b = 1'b1;
        @(negedge clk);
        tao_b = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check({tag, "_wren_in_rst"}, 32'(ram_wren), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        check({tag, "_busy"}, 32'(jtag_busy), 32'h0);
        check({tag, "_mon"}, MonDReg, 32'h0);
        check({tag, "_ovr"}, 32'(jtag_overrun), 32'h0);
        @(negedge clk);
        @(negedge clk);
        check({tag, "_wcount"}, 32'(wcount), 32'(wc0));
        check({tag, "_ram60"}, mem[8'h60], pat(8'h60));
        jtag_op(1, mk_data(1'b0, 32'h0));
        check({tag, "_addr0_read"}, MonDReg, pat(0));
    endtask

    typedef struct {
        int          op;
        logic [7:0]  a;
        logic [31:0] d;
        logic [3:0]  be;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [16];

    logic [31:0] mmem [256];
    logic [7:0]  maddr;
    logic [31:0] mmon;

    initial begin
        int tj;
        int tc;
        int waits;
        int wc0;
        logic [31:0] rd;

        // Reset state, with a CPU read held during reset.
        repeat (2) @(negedge clk);
        ram_init = 1'b0;
        avs_read = 1'b1;
        #1;
        check("rst_waitreq", 32'(avs_waitrequest), 32'h1);
        check("rst_mon", MonDReg, 32'h0);
        check("rst_busy", 32'(jtag_busy), 32'h0);
        check("rst_ovr", 32'(jtag_overrun), 32'h0);
        check("rst_rdata", avs_readdata, 32'h0);
        check("rst_wren", 32'(ram_wren), 32'h0);
        avs_read = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;

        // First contention after reset: JTAG wins in both arbitration modes.
        contend(8'h40, tj, tc, rd);
        check("c1_jtag_first", 32'(tj < tc), 32'h1);
        check("c1_gap", 32'(tc - tj), 32'd2);
        check("c1_rd", rd, pat(8'h40));
        check("c1_mon", MonDReg, pat(0));
        // Lone JTAG re-read leaves JTAG as last grantee.
        jtag_op(2, mk_data(1'b0, 32'h0));
        check("rr_mon", MonDReg, pat(1));
        contend(8'h41, tj, tc, rd);
        check("c2_jtag_first", 32'(tj < tc), 32'(!RR));
        check("c2_gap", 32'(tc - tj), RR ? -32'sd4 : 32'sd2);
        check("c2_rd", rd, pat(8'h41));
        check("c2_mon", MonDReg, pat(1));

        tbl[0]  = '{OP_JA,  8'h10, 32'h0,        4'h0, 32'h0};
        tbl[1]  = '{OP_JW,  8'h00, 32'hDEADBEEF, 4'h0, 32'hDEADBEEF};
        tbl[2]  = '{OP_JR,  8'h00, 32'h0,        4'h0, 32'hA511EE11};
        tbl[3]  = '{OP_CR,  8'h10, 32'h0,        4'h0, 32'hDEADBEEF};
        tbl[4]  = '{OP_JA,  8'hFF, 32'h0,        4'h0, 32'h0};
        tbl[5]  = '{OP_JR,  8'h00, 32'h0,        4'h0, 32'hA5FF00FF};
        tbl[6]  = '{OP_JRR, 8'h00, 32'h0,        4'h0, 32'hA500FF00};
        tbl[7]  = '{OP_JRR, 8'h00, 32'h0,        4'h0, 32'hA500FF00};
        tbl[8]  = '{OP_JR,  8'h00, 32'h0,        4'h0, 32'hA500FF00};
        tbl[9]  = '{OP_JR,  8'h00, 32'h0,        4'h0, 32'hA501FE01};
        tbl[10] = '{OP_CW,  8'h20, 32'h12345678, 4'h3, 32'h0};
        tbl[11] = '{OP_CR,  8'h20, 32'h0,        4'h0, 32'h00005678};
        tbl[12] = '{OP_CW,  8'h21, 32'hCAFEF00D, 4'hC, 32'h0};
        tbl[13] = '{OP_CR,  8'h21, 32'h0,        4'h0, 32'hCAFE0000};
        tbl[14] = '{OP_JA,  8'h21, 32'h0,        4'h0, 32'h0};
        tbl[15] = '{OP_JR,  8'h00, 32'h0,        4'h0, 32'hCAFE0000};

        for (int i = 0; i < 16; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            case (tbl[i].op)
                OP_JA:  jtag_op(0, mk_addr(tbl[i].a));
                OP_JW:  jtag_op(1, mk_data(1'b1, tbl[i].d));
                OP_JR:  jtag_op(1, mk_data(1'b0, tbl[i].d));
                OP_JRR: jtag_op(2, mk_data(1'b0, tbl[i].d));
                OP_CW:  cpu_op(0, 1, tbl[i].a, tbl[i].d, tbl[i].be, rd, waits);
                default: cpu_op(1, 0, tbl[i].a, tbl[i].d, tbl[i].be, rd, waits);
            endcase
            if (tbl[i].op == OP_JW || tbl[i].op == OP_JR || tbl[i].op == OP_JRR)
                check({nm, "_mon"}, MonDReg, tbl[i].exp);
            if (tbl[i].op == OP_CW)
                check({nm, "_waits"}, 32'(waits), 32'd1);
            if (tbl[i].op == OP_CR) begin
                check({nm, "_rd"}, rd, tbl[i].exp);
                check({nm, "_waits"}, 32'(waits), 32'd2);
            end
        end

        // Second data strobe while busy is dropped and flagged.
        check("ovr_before", 32'(jtag_overrun), 32'h0);
        jtag_op(0, mk_addr(8'h30));
        wc0 = wcount;
        @(negedge clk);
        jdo = mk_data(1'b1, 32'h11112222);
        tao_b = 1'b1;
        @(negedge clk);
        jdo = mk_data(1'b1, 32'h33334444);
        @(negedge clk);
        tao_b = 1'b0;
        check("ovr_set", 32'(jtag_overrun), 32'h1);
        for (int n = 0; n < 20 && jtag_busy; n++) @(negedge clk);
        @(negedge clk);
        check("ovr_mon", MonDReg, 32'h11112222);
        check("ovr_ram30", mem[8'h30], 32'h11112222);
        check("ovr_ram31", mem[8'h31], pat(8'h31));
        check("ovr_wcount", 32'(wcount - wc0), 32'd1);

        // Illegal simultaneous read and write behaves as a write.
        cpu_op(1, 1, 8'h50, 32'h5A5AA5A5, 4'hF, rd, waits);
        check("rw_waits", 32'(waits), 32'd1);
        @(negedge clk);
        check("rw_ram50", mem[8'h50], 32'h5A5AA5A5);

        mid_reset(1'b0, "rst_jrd");
        mid_reset(1'b1, "rst_jwr");

        // Random single transactions against a transaction-level model.
        do_reset();
        for (int i = 0; i < 256; i++) mmem[i] = pat(i);
        maddr = '0;
        mmon = '0;
        for (int k = 0; k < 150; k++) begin
            int op;
            logic [7:0] a;
            logic [31:0] d;
            logic [3:0] be;
            op = $urandom_range(0, 5);
            a = 8'($urandom);
            d = $urandom;
            be = 4'($urandom);
            case (op)
                OP_JA: begin
                    jtag_op(0, mk_addr(a));
                    maddr = a;
                end
                OP_JW: begin
                    jtag_op(1, mk_data(1'b1, d));
                    mmem[maddr] = d;
                    mmon = d;
                    maddr = maddr + 8'd1;
                end
                OP_JR: begin
                    jtag_op(1, mk_data(1'b0, d));
                    mmon = mmem[maddr];
                    maddr = maddr + 8'd1;
                end
                OP_JRR: begin
                    jtag_op(2, mk_data(1'b0, d));
                    mmon = mmem[maddr];
                end
                OP_CW: begin
                    cpu_op(0, 1, a, d, be, rd, waits);
                    for (int b = 0; b < 4; b++)
                        if (be[b]) mmem[a][8*b +: 8] = d[8*b +: 8];
                    check($sformatf("rnd%0d_cw_waits", k), 32'(waits), 32'd1);
                end
                default: begin
                    cpu_op(1, 0, a, d, be, rd, waits);
                    check($sformatf("rnd%0d_cr_rd", k), rd, mmem[a]);
                    check($sformatf("rnd%0d_cr_waits", k), 32'(waits), 32'd2);
                end
            endcase
            check($sformatf("rnd%0d_mon", k), MonDReg, mmon);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
